// File: rtl/kc_ifetch_pkg.sv
// kc_ifetch_pkg: shared types and helpers for the KC-LS1u+ instruction fetch buffer
package kc_ifetch_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BYTE0 = 2'd1, BYTE1 = 2'd2} state_t;
    localparam int ENTRIES = 2;
    function automatic logic byte_sel(input logic hi_first, input logic second);
        return hi_first ^ second;
    endfunction
endpackage

// File: rtl/kc_ifetch_entry.sv
// kc_ifetch_entry: one tagged 16-bit instruction buffer entry with byte writes and hit compare
//   clk, rst      clock, async active-high reset
//   i_iaddr       address compared against the tag for o_hit
//   i_clr, i_set  clear / set valid (clear wins); i_set also loads i_tag
//   i_bwe, i_wbyte byte write-enables {hi, lo} and the byte written
//   o_data, o_tag, o_valid, o_hit  entry contents and hit flag
module kc_ifetch_entry #(
    parameter int AW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_iaddr,
    input  logic          i_clr,
    input  logic          i_set,
    input  logic [1:0]    i_bwe,
    input  logic [7:0]    i_wbyte,
    input  logic [AW-1:0] i_tag,
    output logic [15:0]   o_data,
    output logic [AW-1:0] o_tag,
    output logic          o_valid,
    output logic          o_hit
);
    logic [15:0]   r_data;
    logic [AW-1:0] r_tag;
    logic          r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_tag   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_clr ? 1'b0 : (i_set ? 1'b1 : r_valid);
            if (i_set) r_tag <= i_tag;
            if (i_bwe[0]) r_data[7:0] <= i_wbyte;
            if (i_bwe[1]) r_data[15:8] <= i_wbyte;
        end
    end

    assign o_data  = r_data;
    assign o_tag   = r_tag;
    assign o_valid = r_valid;
    assign o_hit   = r_valid && (r_tag == i_iaddr);
endmodule

// File: rtl/kc_ifetch_buf.sv
// kc_ifetch_buf: 2-entry tagged instruction buffer with next-word prefetch over a byte req/ack bus
//   clk, rst          clock, async active-high reset
//   iaddr, inv        core PC, invalidate-all pulse
//   instr, wait_o     instruction for iaddr (0 on miss), core WAIT
//   m_addr, m_req     registered byte address and read request
//   m_ack, m_rdata    memory completion and read byte
module kc_ifetch_buf
    import kc_ifetch_pkg::*;
#(
    parameter int AW       = 24,
    parameter bit HI_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] iaddr,
    input  logic          inv,
    output logic [15:0]   instr,
    output logic          wait_o,
    output logic [AW:0]   m_addr,
    output logic          m_req,
    input  logic          m_ack,
    input  logic [7:0]    m_rdata
);
    state_t        r_state;
    logic [AW-1:0] r_target;
    logic          r_victim;
    logic          r_kill;

    logic [ENTRIES-1:0] w_hit;
    logic [ENTRIES-1:0] w_valid;
    logic [15:0]        w_data [ENTRIES];
    logic [AW-1:0]      w_tag  [ENTRIES];
    logic [AW-1:0]      w_nxt;
    logic [AW-1:0]      w_tgt;
    logic               w_nxt_in;
    logic               w_start;
    logic               w_vict;
    logic               w_ack;
    logic               w_fill;
    logic               w_half;
    logic [1:0]         w_bwe;

    assign w_nxt    = iaddr + 1'b1;
    assign w_nxt_in = (w_valid[0] && w_tag[0] == w_nxt) || (w_valid[1] && w_tag[1] == w_nxt);
    assign w_start  = (r_state == IDLE) && (!(|w_hit) || !w_nxt_in);
    assign w_tgt    = (|w_hit) ? w_nxt : iaddr;
    // A demand miss evicts e0; a prefetch evicts whichever entry iaddr is not hitting.
    assign w_vict   = w_hit[0];
    assign w_ack    = m_ack && (r_state != IDLE);
    // A fetch overlapped by inv still finishes its handshakes but never becomes valid.
    assign w_fill   = m_ack && (r_state == BYTE1) && !inv && !r_kill;
    assign w_half   = byte_sel(HI_FIRST, r_state == BYTE1);
    assign w_bwe    = w_ack ? (w_half ? 2'b10 : 2'b01) : 2'b00;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
        kc_ifetch_entry #(.AW(AW)) u_ent (
            .clk     (clk),
            .rst     (rst),
            .i_iaddr (iaddr),
            .i_clr   (inv || (w_start && w_vict == 1'(i))),
            .i_set   (w_fill && r_victim == 1'(i)),
            .i_bwe   ((r_victim == 1'(i)) ? w_bwe : 2'b00),
            .i_wbyte (m_rdata),
            .i_tag   (r_target),
            .o_data  (w_data[i]),
            .o_tag   (w_tag[i]),
            .o_valid (w_valid[i]),
            .o_hit   (w_hit[i])
        );
    end

    assign instr  = w_hit[0] ? w_data[0] : (w_hit[1] ? w_data[1] : 16'h0000);
    assign wait_o = !(|w_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_victim <= 1'b0;
            r_kill   <= 1'b0;
            m_req    <= 1'b0;
            m_addr   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_start) begin
                    r_state  <= BYTE0;
                    r_target <= w_tgt;
                    r_victim <= w_vict;
                    r_kill   <= 1'b0;
                    m_req    <= 1'b1;
                    m_addr   <= {w_tgt, byte_sel(HI_FIRST, 1'b0)};
                end
                BYTE0: begin
                    r_kill <= r_kill | inv;
                    if (m_ack) begin
                        r_state <= BYTE1;
                        m_addr  <= {r_target, byte_sel(HI_FIRST, 1'b1)};
                    end
                end
                BYTE1: begin
                    r_kill <= r_kill | inv;
                    if (m_ack) begin
                        r_state <= IDLE;
                        m_req   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/kc_ifetch_buf.md
Name: kc_ifetch_buf

Overview:
- Instruction fetch unit sitting directly upstream of the KC-LS1u+ core.
- Supplies the 16-bit `instr` and `WAIT` for the core's current `iaddr`, reading 8-bit program memory through a req/ack byte interface.
- Holds a 2-entry tagged instruction buffer and prefetches `iaddr+1`, so sequential code that hits the buffer runs without stalls.

Parameters:
- AW, 24, instruction (word) address width; byte address width is AW+1.
- HI_FIRST, 0, 0 = fetch low byte (even address) first; 1 = fetch high byte first.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- iaddr  in  AW  core current PC
- inv  in  1  invalidate both buffer entries (pulse)
- instr  out  16  instruction for iaddr; 0 when no hit
- wait_o  out  1  to core WAIT; 1 = instr not valid for iaddr
- m_addr  out  AW+1  byte address; instruction A occupies bytes 2A (bits 7:0) and 2A+1 (bits 15:8)
- m_req  out  1  byte read request
- m_ack  in  1  memory completes the request this cycle
- m_rdata  in  8  read byte, valid while m_ack=1

Behaviour:
- Storage: entry e0/e1, each holding data[15:0], tag[AW-1:0] and valid.
- Hit: entry valid and tag==iaddr.
  - instr = data of the hitting entry, else 16'h0000.
  - wait_o = !(hit0|hit1), purely combinational from iaddr and registered state; no dependence on the core's iaddr_next (avoids a loop).
- Reset: valid bits 0, FSM IDLE, m_req 0, m_addr 0, instr 0, wait_o 1.
- FSM states IDLE, BYTE0, BYTE1; m_req and m_addr are registered.
  - IDLE, demand miss (no hit):
    - target = iaddr; victim = e0.
    - Clear victim.valid; go BYTE0.
  - IDLE, hit, and iaddr+1 (mod 2^AW) present in neither entry:
    - target = iaddr+1 (prefetch); victim = the non-hitting entry.
    - Clear victim.valid; go BYTE0.
  - IDLE, otherwise: stay.
  - BYTE0:
    - m_req=1; m_addr = {target, HI_FIRST}.
    - On m_ack, latch m_rdata into that half of victim.data; go BYTE1.
  - BYTE1:
    - m_req=1; m_addr = {target, !HI_FIRST}.
    - On m_ack, write the other half; victim.tag=target, victim.valid=1; go IDLE.
  - BYTE0→BYTE1: m_req deasserts for at most zero cycles; m_addr changes on the transition edge.
- Handshake:
  - m_req/m_addr stay stable until m_ack is sampled high.
  - A request is never withdrawn once raised; no abort mid-handshake.
- Target latched at fetch start. If the core jumps while a prefetch is in flight, the fetch completes and is written anyway (it is tagged, so harmless); a demand miss then starts from IDLE.
- Miss latency, zero-wait memory (ack in the first req cycle):
  - miss seen in cycle t (IDLE) → req in t+1, t+2 → entry valid after edge ending t+2 → wait_o=0 in t+3.
  - Each memory wait state adds 1 cycle.
- Sequential stream is memory-bound: at most 1 instruction per 2 cycles after the first.
- Address wrap: prefetch of iaddr = 2^AW-1 targets 0.
- Victim invariant: the entry hit by the current iaddr is never chosen as victim, so instr is stable while the core reads it.
- inv:
  - clears both valid bits at the next edge; wait_o=1 the following cycle.
  - If a fetch is in flight, it completes its handshakes but its final valid write is suppressed.
  - inv together with a completing BYTE1 → entry stays invalid.
- While the core sees wait_o=1 it holds iaddr; the unit must not depend on the core for progress.
- Async reset mid-handshake: m_req drops immediately and the state is lost; the memory must tolerate an abandoned request.

Decomposition:
- Package kc_ifetch_pkg:
  - state enum {IDLE, BYTE0, BYTE1}
  - localparam ENTRIES=2
  - byte-select helper constant for HI_FIRST
- Optional sub-module kc_ifetch_entry: one tagged entry (data, tag, valid) with byte write-enables and hit compare; instantiated twice. FSM and victim selection stay in the top level.

Test Plan:
- Reset, iaddr=0, memory bytes 0x34@0, 0x12@1, zero-wait → m_addr 0 then 1, wait_o=0 from cycle 3, instr=0x1234; then prefetch m_addr 2,3 starts.
- Core steps iaddr 0→1→2 each cycle wait_o=0, with words 0x1234,0xABCD,0x5555 → instr correct each hit; wait_o=1 on iaddr=2 until its fetch completes; no entry overwritten while hit.
- Memory with 2 wait states (ack on 3rd req cycle) → m_req held, m_addr stable across waits; miss latency 7 cycles.
- Jump during prefetch: prefetch of 5 in flight, iaddr→0x100 → fetch 5 completes, then demand fetch byte addresses 0x200/0x201; instr valid for 0x100 afterwards.
- inv asserted in the same cycle as BYTE1 ack → entry not valid, wait_o=1, refetch issued.
- iaddr=24'hFFFFFF hit → prefetch m_addr 0 and 1 (wrap); HI_FIRST=1 build → high byte fetched first, assembled word identical.
